piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage that consumes WIDTH-bit words from the SIPO output side.
//  The SIPO output side is the data_o/valid_o/ready_i interface on pclk_i.
//  Each word is shifted out one bit per serial handshake, with first-bit and last-bit markers.
//  A one-entry hold buffer plus a shift register give gap-free back-to-back words.
//  Completes the SIPO_to_PISO loop-back path.
// PARAMETERS
//  WIDTH      8  word width; bit counter is $clog2(WIDTH) bits
//  LSB_FIRST  1  1: bit 0 first (matches SIPO packing order); 0: bit WIDTH-1 first
// PORTS
//  pclk_i   in   1      single clock; all logic on rising edge
//  rst_i    in   1      reset, asynchronous, active-high
//  data_i   in   WIDTH  parallel word from upstream
//  valid_i  in   1      upstream word valid
//  ready_o  out  1      block can accept a word; a word transfers on valid_i && ready_o
//  data_o   out  1      serial bit
//  valid_o  out  1      data_o valid; a bit transfers on valid_o && ready_i
//  sof_o    out  1      high with the first bit of each word
//  eof_o    out  1      high with the last bit of each word
//  ready_i  in   1      downstream can accept a bit
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - hold_vld=0, shift_vld=0, bit_cnt=0, state=S_IDLE.
//   - data_o=0, valid_o=0, sof_o=0, eof_o=0.
//   - ready_o is forced 0 while rst_i=1.
//   - Reset mid-word discards both the shifting word and the held word; no partial word resumes.
//  ready_o = !rst_i && !hold_vld. It is combinational from registers only; there is no path from ready_i.
//  Accept: on an edge with valid_i && ready_o:
//   - the word goes straight into the shift register if the shift register is empty or freeing this edge;
//   - otherwise it goes into the hold buffer.
//  Free this edge means shift_vld && valid_o && ready_i && bit_cnt==WIDTH-1.
//  On free, hold (if valid) moves into the shift register and hold_vld clears. Hold takes priority over a direct load.
//  Latency: word accepted at edge N gives its first bit on data_o after edge N (registered), when the shifter was idle.
//  Throughput:
//   - one word per WIDTH bit-transfers;
//   - no bubble between words when the hold buffer was filled before the last bit;
//   - sustained ready_i=1 streams continuously.
//  FSM (one-hot):
//   - S_IDLE (2'b01): valid_o=0. Goes to S_SHIFT on load.
//   - S_SHIFT (2'b10): valid_o=1, bit_cnt advances per bit-transfer. At the last bit it returns to S_IDLE if no word is held or accepted, else reloads and stays in S_SHIFT with bit_cnt=0.
//  Stall: with ready_i=0, data_o, sof_o, eof_o, valid_o and bit_cnt hold; a valid_o/data_o already presented is never retracted.
//  sof_o = valid_o && bit_cnt==0; eof_o = valid_o && bit_cnt==WIDTH-1 (both asserted when WIDTH==1).
//  data_o = LSB_FIRST ? shreg[bit_cnt] : shreg[WIDTH-1-bit_cnt]. This is an index mux; there is no physical shift, so there is no wrap hazard.
//  Simultaneous events:
//   - With hold full and the last bit transferring, hold moves to shift and ready_o rises next cycle.
//   - With hold empty and the last bit transferring with valid_i=1, the input loads directly into shift.
//  valid_i is ignored while ready_o=0; data_i is sampled only on accept.
// STRUCTURE
//  Shared package piso_pkg: S_IDLE/S_SHIFT encodings and the default WIDTH constant.
//  One sub-module, piso_hold_buf: a one-entry registered buffer with in valid/ready and out valid/ready, plus async reset.
//  The shift register, bit counter and FSM stay in piso_serializer.
// TESTING
//  1. Reset: assert rst_i at bit 3 of 0xA5 -> same cycle valid_o=0, data_o=0, ready_o=0; after release ready_o=1, no stale bits.
//  2. Single word 0xA5, ready_i=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles from edge after accept; sof_o on bit 1, eof_o on bit 8.
//  3. Back-to-back 0x3C then 0xC3, ready_i=1 -> 16 contiguous valid bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1; ready_o low while hold full.
//  4. Stall: 0x5A, ready_i=0 for 3 cycles at bit index 4 -> data_o=1 held with valid_o=1 for 3 cycles; full word intact, eof_o on bit 8.
//  5. LSB_FIRST=0, word 0x01 -> bits 0,0,0,0,0,0,0,1; sof_o on first, eof_o on the '1'.
//  6. Stream 4 words 0x00,0xFF,0x81,0x7E with valid_i=1 always -> 32 contiguous bits, exactly 4 sof_o/eof_o pulses, no drops or duplicates.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//   state_e       : one-hot FSM encoding (S_IDLE = shifter empty, S_SHIFT = bits presented)
//   DEFAULT_WIDTH : default parallel word width
package piso_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_e;

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry registered buffer used as the word hold stage in front of the shifter.
//   pclk_i      in   clock, rising edge
//   rst_i       in   asynchronous active-high reset, clears the entry
//   in_valid_i  in   write request
//   in_ready_o  out  entry empty; a write happens on in_valid_i && in_ready_o
//   in_data_i   in   word to store
//   out_valid_o out  entry holds a word
//   out_ready_i in   consumer takes the word; it leaves on out_valid_o && out_ready_i
//   out_data_o  out  stored word
module piso_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready_o  = !vld_q;
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (vld_q && out_ready_i) begin
      vld_d = 1'b0;
    end
    if (in_valid_i && !vld_q) begin
      vld_d  = 1'b1;
      data_d = in_data_i;
    end
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: takes WIDTH-bit words and presents them one
// bit per downstream handshake, flagging the first and last bit of every word.
// A one-entry hold buffer in front of the shift register lets the next word wait
// so back-to-back words leave with no bubble.
//   pclk_i   in   clock, rising edge
//   rst_i    in   asynchronous active-high reset (released synchronously upstream)
//   data_i   in   parallel word
//   valid_i  in   word valid
//   ready_o  out  word can be taken
//   data_o   out  serial bit
//   valid_o  out  serial bit valid
//   sof_o    out  first bit of a word
//   eof_o    out  last bit of a word
//   ready_i  in   downstream takes the bit
//
// Handshakes: a word moves on the rising edge where valid_i && ready_o, a bit
// moves on the rising edge where valid_o && ready_i. Once valid_o is raised the
// presented bit and markers stay stable until that bit is taken. ready_o depends
// only on registers (and rst_i), never on ready_i.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic             pclk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             data_o,
  output logic             valid_o,
  output logic             sof_o,
  output logic             eof_o,
  input  logic             ready_i
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_idx;

  logic             accept;
  logic             shift_vld;
  logic             free;
  logic             hold_in_valid;
  logic             hold_in_ready;
  logic             hold_vld;
  logic [WIDTH-1:0] hold_data;

  assign shift_vld = (state_q == S_SHIFT);
  assign ready_o   = !rst_i && hold_in_ready;
  assign accept    = valid_i && ready_o;
  // The shifter empties on this edge when its last bit is being taken.
  assign free      = shift_vld && ready_i && (bit_cnt_q == LAST);
  // A word only parks in the hold buffer when the shifter is busy and stays busy.
  assign hold_in_valid = accept && shift_vld && !free;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .pclk_i      (pclk_i),
    .rst_i       (rst_i),
    .in_valid_i  (hold_in_valid),
    .in_ready_o  (hold_in_ready),
    .in_data_i   (data_i),
    .out_valid_o (hold_vld),
    .out_ready_i (free),
    .out_data_o  (hold_data)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          shreg_d   = data_i;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (ready_i) begin
          if (bit_cnt_q == LAST) begin
            bit_cnt_d = '0;
            // The held word is older than anything arriving now, so it goes first.
            if (hold_vld) begin
              shreg_d = hold_data;
            end else if (accept) begin
              shreg_d = data_i;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  // Bit selection is an index mux over a static word, not a physical shift.
  assign bit_idx = (LSB_FIRST != 0) ? bit_cnt_q : (LAST - bit_cnt_q);
  assign valid_o = shift_vld;
  assign data_o  = shift_vld && shreg_q[bit_idx];
  assign sof_o   = shift_vld && (bit_cnt_q == '0);
  assign eof_o   = shift_vld && (bit_cnt_q == LAST);

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] data_i;
  logic         valid_i;
  logic         ready_i;
  logic         ready_o, data_o, valid_o, sof_o, eof_o;
  logic         m_ready_o, m_data_o, m_valid_o, m_sof_o, m_eof_o;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut (
    .pclk_i (clk), .rst_i (rst_i), .data_i (data_i), .valid_i (valid_i),
    .ready_o (ready_o), .data_o (data_o), .valid_o (valid_o),
    .sof_o (sof_o), .eof_o (eof_o), .ready_i (ready_i)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .pclk_i (clk), .rst_i (rst_i), .data_i (data_i), .valid_i (valid_i),
    .ready_o (m_ready_o), .data_o (m_data_o), .valid_o (m_valid_o),
    .sof_o (m_sof_o), .eof_o (m_eof_o), .ready_i (ready_i)
  );

  // Reference model: queue of bits still owed downstream, {sof, eof, lsb-first bit, msb-first bit}.
  logic [3:0] exp_q[$];
  logic       cap_l[$];
  logic       cap_m[$];
  int         sof_cnt, eof_cnt, cyc, first_x, last_x;
  int         n_cmp = 0;
  int         n_err = 0;
  logic       last_acc;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] seq_lsb;  // expected serial order, first bit in the MSB position
    logic [W-1:0] seq_msb;
  } vec_t;
  vec_t tbl[6];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_cap();
    cap_l.delete();
    cap_m.delete();
    sof_cnt = 0;
    eof_cnt = 0;
    first_x = -1;
    last_x  = -1;
  endtask

  task automatic chk_seq(input string nm, input logic msb, input logic [31:0] exp, input int n);
    logic [31:0] got;
    int          sz;
    got = '0;
    sz  = msb ? cap_m.size() : cap_l.size();
    chk32({nm, "_len"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++) got[n-1-i] = msb ? cap_m[i] : cap_l[i];
    chk32(nm, got, exp);
  endtask

  task automatic check_outputs();
    if (rst_i) begin
      chk1("rst_ready", ready_o, 1'b0);
      chk1("rst_valid", valid_o, 1'b0);
      chk1("rst_data", data_o, 1'b0);
    end else begin
      chk1("ready", ready_o, exp_q.size() <= W);
      chk1("valid", valid_o, exp_q.size() != 0);
      chk1("valid_msb", m_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk1("sof", sof_o, exp_q[0][3]);
        chk1("eof", eof_o, exp_q[0][2]);
        chk1("data_lsb", data_o, exp_q[0][1]);
        chk1("data_msb", m_data_o, exp_q[0][0]);
      end
    end
  endtask

  // Called just after a falling edge: drive inputs, advance one clock, check.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
    logic acc, xfer;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    acc  = v && !rst_i && (exp_q.size() <= W);
    xfer = r && !rst_i && (exp_q.size() != 0);
    last_acc = acc;
    if (xfer) begin
      cap_l.push_back(data_o);
      cap_m.push_back(m_data_o);
      if (sof_o) sof_cnt++;
      if (eof_o) eof_cnt++;
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
    end
    @(posedge clk);
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        for (int k = 0; k < W; k++)
          exp_q.push_back({k == 0, k == W - 1, d[k], d[W-1-k]});
      end
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [W-1:0] words[4];
    int           idx;

    tbl[0] = '{8'hA5, 8'b1010_0101, 8'b1010_0101};
    tbl[1] = '{8'h01, 8'b1000_0000, 8'b0000_0001};
    tbl[2] = '{8'h3C, 8'b0011_1100, 8'b0011_1100};
    tbl[3] = '{8'h12, 8'b0100_1000, 8'b0001_0010};
    tbl[4] = '{8'h80, 8'b0000_0001, 8'b1000_0000};
    tbl[5] = '{8'h5A, 8'b0101_1010, 8'b0101_1010};
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h81; words[3] = 8'h7E;
    cyc = 0;
    clear_cap();

    // Reset state
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
    @(negedge clk);
    cycle(1'b1, 8'hFF, 1'b1);
    chk1("reset_sof", sof_o, 1'b0);
    chk1("reset_eof", eof_o, 1'b0);
    rst_i = 1'b0;
    cycle(1'b0, '0, 1'b1);

    // Single words, both bit orders
    foreach (tbl[t]) begin
      clear_cap();
      cycle(1'b1, tbl[t].word, 1'b1);
      chk1("first_bit_valid", valid_o, 1'b1);
      chk1("first_bit_sof", sof_o, 1'b1);
      for (int i = 0; i < W + 1; i++) cycle(1'b0, '0, 1'b1);
      chk_seq("tbl_lsb", 1'b0, 32'(tbl[t].seq_lsb), W);
      chk_seq("tbl_msb", 1'b1, 32'(tbl[t].seq_msb), W);
      chk32("tbl_sof_cnt", 32'(sof_cnt), 32'd1);
      chk32("tbl_eof_cnt", 32'(eof_cnt), 32'd1);
    end

    // Reset in the middle of a word
    clear_cap();
    cycle(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    chk1("pre_reset_bit3", data_o, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk1("async_rst_valid", valid_o, 1'b0);
    chk1("async_rst_data", data_o, 1'b0);
    chk1("async_rst_ready", ready_o, 1'b0);
    @(negedge clk);
    cycle(1'b0, '0, 1'b1);
    rst_i = 1'b0;
    clear_cap();
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
    chk32("no_stale_bits", 32'(cap_l.size()), 32'd0);

    // Back-to-back words through the hold buffer
    clear_cap();
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b1, 8'hC3, 1'b1);
    chk1("b2b_second_acc", last_acc, 1'b1);
    chk1("b2b_hold_full_ready", ready_o, 1'b0);
    for (int i = 0; i < 18; i++) cycle(1'b0, '0, 1'b1);
    chk_seq("b2b_bits", 1'b0, 32'b0011_1100_1100_0011, 16);
    chk32("b2b_span", 32'(last_x - first_x + 1), 32'd16);

    // Stall at bit index 4
    clear_cap();
    cycle(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, '0, 1'b0);
      chk1("stall_data", data_o, 1'b1);
      chk1("stall_valid", valid_o, 1'b1);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1);
    chk_seq("stall_word", 1'b0, 32'b0101_1010, 8);
    chk32("stall_eof_cnt", 32'(eof_cnt), 32'd1);

    // Continuous stream of four words
    clear_cap();
    idx = 0;
    for (int i = 0; i < 60 && idx < 4; i++) begin
      cycle(1'b1, words[idx], 1'b1);
      if (last_acc) idx++;
    end
    chk32("stream_accepted", 32'(idx), 32'd4);
    for (int i = 0; i < 3 * W; i++) cycle(1'b0, '0, 1'b1);
    chk_seq("stream_bits", 1'b0, 32'b00000000_11111111_10000001_01111110, 32);
    chk32("stream_sof_cnt", 32'(sof_cnt), 32'd4);
    chk32("stream_eof_cnt", 32'(eof_cnt), 32'd4);
    chk32("stream_span", 32'(last_x - first_x + 1), 32'd32);

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_i = 1'b1;
        cycle(1'($urandom_range(0, 1)), W'($urandom), 1'b1);
        rst_i = 1'b0;
      end
      cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3 * W; i++) cycle(1'b0, '0, 1'b1);
    chk32("drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
